// File: rtl/video_pkg.sv
// Shared capture defaults, FSM state type and the colour truncation helper
// used by the Mega Drive raster tracker.
package video_pkg;

  localparam int DEF_W = 320;
  localparam int DEF_H = 224;

  typedef enum logic {
    SEEK,
    ACTIVE
  } cap_state_t;

  // Keeps the top out_bits of an in_bits-wide channel; channels up to 16 bits wide.
  function automatic logic [15:0] color_msbs(input logic [15:0] chan,
                                              input int          in_bits,
                                              input int          out_bits);
    return chan >> (in_bits - out_bits);
  endfunction

endpackage

// File: rtl/video_dim_filter.sv
// Commits a measured frame dimension only when two consecutive valid
// candidates agree, so a single odd frame never disturbs the output.
module video_dim_filter
  import video_pkg::*;
#(
  parameter int         W         = 11,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [W-1:0] cand,
  output logic [W-1:0] value
);

  logic [W-1:0] r_prevCand;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prevCand <= '0;
      value      <= RESET_VAL;
    end else if (valid) begin
      r_prevCand <= cand;
      if (cand == r_prevCand) begin
        value <= cand;
      end
    end
  end

endmodule

// File: rtl/md_video_capture.sv
// Raster tracker for the VDP output: single-cycle pixel strobe with x/y,
// truncated colour and a stability-filtered measurement of the active frame.
module md_video_capture
  import video_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int IN_BITS    = 8,
  parameter int COLOR_BITS = 4,
  parameter int DEF_W      = video_pkg::DEF_W,
  parameter int DEF_H      = video_pkg::DEF_H
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce_pix_in,
  input  logic                      hblank,
  input  logic                      vblank,
  input  logic [IN_BITS-1:0]        r_in,
  input  logic [IN_BITS-1:0]        g_in,
  input  logic [IN_BITS-1:0]        b_in,
  output logic                      ce_pix,
  output logic [COLOR_BITS-1:0]     r,
  output logic [COLOR_BITS-1:0]     g,
  output logic [COLOR_BITS-1:0]     b,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic [10:0]               width,
  output logic [9:0]                height,
  output logic                      frame_start,
  output logic                      overrun
);

  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int XCW = $clog2(WIDTH + 1);
  localparam int YCW = $clog2(HEIGHT + 1);

  cap_state_t r_state;
  cap_state_t w_nextState;

  logic           r_hblank;
  logic           r_vblank;
  logic           r_cePrev;
  logic [XCW-1:0] r_xCnt;
  logic [YCW-1:0] r_yCnt;
  logic [XCW-1:0] r_lineMax;

  logic           w_hRise;
  logic           w_vRise;
  logic           w_vFall;
  logic           w_accept;
  logic           w_strobe;
  logic           w_lineEnd;
  logic [XCW-1:0] w_lineMaxUpd;
  logic [YCW-1:0] w_yCntUpd;
  logic [10:0]    w_candW;
  logic [9:0]     w_candH;
  logic           w_candValid;

  logic [COLOR_BITS-1:0] w_rMsb;
  logic [COLOR_BITS-1:0] w_gMsb;
  logic [COLOR_BITS-1:0] w_bMsb;

  assign w_hRise = hblank & ~r_hblank;
  assign w_vRise = vblank & ~r_vblank;
  assign w_vFall = ~vblank & r_vblank;

  // The previous-cycle strobe check drops the second half of a doubled pulse.
  assign w_accept = (r_state == ACTIVE) & ce_pix_in & ~hblank & ~vblank & ~r_cePrev;
  assign w_strobe = w_accept & (r_xCnt < XCW'(WIDTH));

  assign w_rMsb = COLOR_BITS'(color_msbs(16'(r_in), IN_BITS, COLOR_BITS));
  assign w_gMsb = COLOR_BITS'(color_msbs(16'(g_in), IN_BITS, COLOR_BITS));
  assign w_bMsb = COLOR_BITS'(color_msbs(16'(b_in), IN_BITS, COLOR_BITS));

  // Line-end results are formed here so a coincident frame end sees them.
  assign w_lineEnd    = w_hRise & (r_xCnt != '0);
  assign w_lineMaxUpd = (w_lineEnd && (r_xCnt > r_lineMax)) ? r_xCnt : r_lineMax;
  assign w_yCntUpd    = (w_lineEnd && (r_yCnt != YCW'(HEIGHT))) ? r_yCnt + YCW'(1) : r_yCnt;

  assign w_candW     = (w_lineMaxUpd > XCW'(WIDTH)) ? 11'(WIDTH)  : 11'(w_lineMaxUpd);
  assign w_candH     = (w_yCntUpd    > YCW'(HEIGHT)) ? 10'(HEIGHT) : 10'(w_yCntUpd);
  assign w_candValid = w_vRise & (w_candW != '0) & (w_candH != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEEK;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SEEK:    if (w_vFall) w_nextState = ACTIVE;
      ACTIVE:  w_nextState = ACTIVE;
      default: w_nextState = SEEK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hblank  <= 1'b1;
      r_vblank  <= 1'b1;
      r_cePrev  <= 1'b0;
      r_xCnt    <= '0;
      r_yCnt    <= '0;
      r_lineMax <= '0;
    end else begin
      r_hblank <= hblank;
      r_vblank <= vblank;
      r_cePrev <= ce_pix_in;
      if (w_hRise) begin
        r_xCnt <= '0;
      end else if (w_accept && (r_xCnt != XCW'(WIDTH))) begin
        r_xCnt <= r_xCnt + XCW'(1);
      end
      if (w_vRise) begin
        r_yCnt    <= '0;
        r_lineMax <= '0;
      end else begin
        r_yCnt    <= w_yCntUpd;
        r_lineMax <= w_lineMaxUpd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_pix      <= 1'b0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
      x           <= '0;
      y           <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      ce_pix      <= w_strobe;
      frame_start <= w_vFall;
      overrun     <= overrun | (ce_pix_in & r_cePrev);
      if (w_strobe) begin
        x <= XW'(r_xCnt);
        y <= YW'(r_yCnt);
        r <= w_rMsb;
        g <= w_gMsb;
        b <= w_bMsb;
      end
    end
  end

  video_dim_filter #(
    .W         (11),
    .RESET_VAL (11'(DEF_W))
  ) u_widthFilter (
    .clk   (clk),
    .reset (reset),
    .valid (w_candValid),
    .cand  (w_candW),
    .value (width)
  );

  video_dim_filter #(
    .W         (10),
    .RESET_VAL (10'(DEF_H))
  ) u_heightFilter (
    .clk   (clk),
    .reset (reset),
    .valid (w_candValid),
    .cand  (w_candH),
    .value (height)
  );

endmodule

// File: tb/tb_md_video_capture.sv
// Bench for md_video_capture: a rule-level raster model is compared against
// every output each cycle, with literal expectations at key points.
module tb_md_video_capture;

  localparam int WIDTH      = 320;
  localparam int HEIGHT     = 240;
  localparam int IN_BITS    = 8;
  localparam int COLOR_BITS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       ce_pix_in;
  logic       hblank;
  logic       vblank;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic       ce_pix;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic [8:0] x;
  logic [7:0] y;
  logic [10:0] width;
  logic [9:0]  height;
  logic       frame_start;
  logic       overrun;

  md_video_capture #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .IN_BITS    (IN_BITS),
    .COLOR_BITS (COLOR_BITS),
    .DEF_W      (320),
    .DEF_H      (224)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce_pix_in   (ce_pix_in),
    .hblank      (hblank),
    .vblank      (vblank),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .ce_pix      (ce_pix),
    .r           (r),
    .g           (g),
    .b           (b),
    .x           (x),
    .y           (y),
    .width       (width),
    .height      (height),
    .frame_start (frame_start),
    .overrun     (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Raster model state, expressed directly in terms of lines, columns and frames
  bit modelOn = 1'b0;
  bit mCap, mPCe, mPH, mPV;
  int mXc, mYc, mLm, mPcw, mPch;
  int eCe, eX, eY, eR, eG, eB, eFs, eOver, eW, eH;

  int strobeCount = 0;
  int maxX = 0;
  int maxY = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit hR, vR, vF, acc;
    int cw, ch;
    if (reset) begin
      mCap = 0; mPCe = 0; mPH = 1; mPV = 1;
      mXc = 0; mYc = 0; mLm = 0; mPcw = 0; mPch = 0;
      eCe = 0; eX = 0; eY = 0; eR = 0; eG = 0; eB = 0;
      eFs = 0; eOver = 0; eW = 320; eH = 224;
      modelOn = 1'b1;
      return;
    end
    hR  = hblank && !mPH;
    vR  = vblank && !mPV;
    vF  = !vblank && mPV;
    acc = mCap && ce_pix_in && !hblank && !vblank && !mPCe;
    eCe = 0;
    if (acc) begin
      if (mXc < WIDTH) begin
        eCe = 1;
        eX  = mXc;
        eY  = mYc;
        eR  = int'(r_in) >> (IN_BITS - COLOR_BITS);
        eG  = int'(g_in) >> (IN_BITS - COLOR_BITS);
        eB  = int'(b_in) >> (IN_BITS - COLOR_BITS);
        mXc = mXc + 1;
      end
    end
    if (ce_pix_in && mPCe) eOver = 1;
    if (hR) begin
      if (mXc > 0) begin
        if (mXc > mLm) mLm = mXc;
        if (mYc < HEIGHT) mYc = mYc + 1;
      end
      mXc = 0;
    end
    if (vR) begin
      cw = (mLm > WIDTH) ? WIDTH : mLm;
      ch = (mYc > HEIGHT) ? HEIGHT : mYc;
      if (cw != 0 && ch != 0) begin
        if (cw == mPcw) eW = cw;
        if (ch == mPch) eH = ch;
        mPcw = cw;
        mPch = ch;
      end
      mYc = 0;
      mLm = 0;
    end
    eFs = vF ? 1 : 0;
    if (vF) mCap = 1;
    mPH  = hblank;
    mPV  = vblank;
    mPCe = ce_pix_in;
  endtask

  always @(negedge clk) begin
    if (modelOn) begin
      checkVal("ce_pix",      32'(ce_pix),      32'(eCe));
      checkVal("x",           32'(x),           32'(eX));
      checkVal("y",           32'(y),           32'(eY));
      checkVal("r",           32'(r),           32'(eR));
      checkVal("g",           32'(g),           32'(eG));
      checkVal("b",           32'(b),           32'(eB));
      checkVal("frame_start", 32'(frame_start), 32'(eFs));
      checkVal("overrun",     32'(overrun),     32'(eOver));
      checkVal("width",       32'(width),       32'(eW));
      checkVal("height",      32'(height),      32'(eH));
      if (ce_pix === 1'b1) begin
        strobeCount++;
        if (int'(x) > maxX) maxX = int'(x);
        if (int'(y) > maxY) maxY = int'(y);
      end
    end
  end

  task automatic cycleIn(input bit rst, input bit ce, input bit h, input bit v,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    reset     = rst;
    ce_pix_in = ce;
    hblank    = h;
    vblank    = v;
    r_in      = rr;
    g_in      = gg;
    b_in      = bb;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulusLine(input int n, input int yIdx, input bit endFrame);
    for (int i = 0; i < n; i++) begin
      cycleIn(1'b0, 1'b1, 1'b0, 1'b0, 8'(i * 3 + yIdx), 8'(i ^ (yIdx << 4)), 8'(255 - i));
      cycleIn(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h0F);
    end
    for (int k = 0; k < 3; k++) cycleIn(1'b0, 1'b0, 1'b1, endFrame, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic applyStimulusFrame(input int w, input int lines, input bit simul, input bit fallPix);
    cycleIn(1'b0, fallPix, !fallPix, 1'b0, 8'hF0, 8'h0F, 8'h33);
    checkVal("frame_start_pulse", 32'(frame_start), 32'd1);
    if (fallPix) checkVal("fall_pixel_ignored", 32'(ce_pix), 32'd0);
    cycleIn(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    checkVal("frame_start_single", 32'(frame_start), 32'd0);
    for (int l = 0; l < lines; l++) applyStimulusLine(w, l, simul && (l == lines - 1));
    if (!simul) begin
      for (int k = 0; k < 3; k++) cycleIn(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) cycleIn(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    checkVal("reset_width",   32'(width),   32'd320);
    checkVal("reset_height",  32'(height),  32'd224);
    checkVal("reset_x",       32'(x),       32'd0);
    checkVal("reset_ce_pix",  32'(ce_pix),  32'd0);
    checkVal("reset_overrun", 32'(overrun), 32'd0);

    strobeCount = 0;
    for (int k = 0; k < 4; k++) begin
      cycleIn(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
      cycleIn(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    end
    checkVal("seek_no_strobe", 32'(strobeCount), 32'd0);

    applyStimulusFrame(256, 6, 1'b0, 1'b1);
    checkVal("width_after_one_frame",  32'(width),  32'd320);
    checkVal("height_after_one_frame", 32'(height), 32'd224);

    maxX = 0;
    maxY = 0;
    applyStimulusFrame(256, 6, 1'b0, 1'b0);
    checkVal("width_after_two_frames",  32'(width),  32'd256);
    checkVal("height_after_two_frames", 32'(height), 32'd6);
    checkVal("max_x_256", 32'(maxX), 32'd255);
    checkVal("max_y_6",   32'(maxY), 32'd5);

    applyStimulusFrame(320, 8, 1'b0, 1'b0);
    applyStimulusFrame(256, 6, 1'b0, 1'b0);
    checkVal("width_after_glitch",  32'(width),  32'd256);
    checkVal("height_after_glitch", 32'(height), 32'd6);

    applyStimulusFrame(330, 4, 1'b0, 1'b0);
    strobeCount = 0;
    maxX = 0;
    applyStimulusFrame(330, 4, 1'b1, 1'b0);
    checkVal("strobes_330_lines", 32'(strobeCount), 32'd1280);
    checkVal("max_x_clamped",     32'(maxX),        32'd319);
    checkVal("width_clamped",     32'(width),       32'd320);
    checkVal("height_4",          32'(height),      32'd4);

    cycleIn(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cycleIn(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cycleIn(1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
    cycleIn(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    cycleIn(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkVal("overrun_set", 32'(overrun), 32'd1);
    checkVal("double_pulse_x", 32'(x), 32'd0);
    for (int i = 1; i < 100; i++) begin
      cycleIn(1'b0, 1'b1, 1'b0, 1'b0, 8'(i), 8'(i), 8'(i));
      cycleIn(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    end
    checkVal("overrun_sticky",   32'(overrun), 32'd1);
    checkVal("x_before_reset",   32'(x),       32'd99);

    cycleIn(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cycleIn(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkVal("midreset_overrun", 32'(overrun), 32'd0);
    checkVal("midreset_width",   32'(width),   32'd320);
    checkVal("midreset_height",  32'(height),  32'd224);
    checkVal("midreset_x",       32'(x),       32'd0);

    cycleIn(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    cycleIn(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    cycleIn(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    checkVal("restart_frame_start", 32'(frame_start), 32'd1);
    cycleIn(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cycleIn(1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h40, 8'h20);
      cycleIn(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    end
    checkVal("restart_x", 32'(x), 32'd2);
    checkVal("restart_y", 32'(y), 32'd0);
    checkVal("restart_r", 32'(r), 32'd8);
    for (int k = 0; k < 3; k++) cycleIn(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
